// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RISC-V widths, the canonical NOP encoding and the fetch queue entry type.
package riscv_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry response queue between the imem response channel and the F/D register.
module fetch_fifo
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         srst,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    output fetch_entry_t head_o,
    output logic [1:0]   count_o
);
    fetch_entry_t mem_q [2];
    logic         wr_q, rd_q;
    logic [1:0]   count_q;

    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_q] <= push_data_i;
    end

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            count_q <= 2'd0;
        end else if (flush_i) begin
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push_i) wr_q <= !wr_q;
            if (pop_i) rd_q <= !rd_q;
            count_q <= count_q + 2'(push_i) - 2'(pop_i);
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC generation, imem request/response tracking and the F/D pipeline register.
// Define FETCH_PERF_CNT_EN to build the saturating fetch/bubble performance counters.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            srst,
    input  logic            stall_f,
    input  logic            stall_d,
    input  logic            flush_d,
    input  logic            pcsrc_e,
    input  logic [XLEN-1:0] pc_target_e,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic [XLEN-1:0] instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus4_d,
    output logic            valid_d,
    output logic [XLEN-1:0] fetch_cnt,
    output logic [XLEN-1:0] bubble_cnt
);
    logic [XLEN-1:0] pc_f_q, pc_rsp_q, instr_q, pc_q, pc_plus4_q;
    logic [1:0]      outst_q, drop_q, fifo_cnt;
    logic            valid_q, req_fire, rsp_fire, push, pop, bubble;
    fetch_entry_t    head, push_entry;

    assign imem_req_valid = !srst && !stall_f && !pcsrc_e && ({1'b0, outst_q} + {1'b0, fifo_cnt} < 3'd2);
    assign imem_req_addr  = pc_f_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_fire       = imem_rsp_valid && outst_q != 2'd0;
    assign push           = rsp_fire && drop_q == 2'd0 && !pcsrc_e;
    assign pop            = !flush_d && !pcsrc_e && !stall_d && fifo_cnt != 2'd0;
    assign bubble         = flush_d || pcsrc_e || (!stall_d && fifo_cnt == 2'd0);
    assign push_entry     = '{pc: pc_rsp_q, instr: imem_rsp_data};

    fetch_fifo u_fifo (
        .clk        (clk),
        .srst       (srst),
        .flush_i    (pcsrc_e),
        .push_i     (push),
        .push_data_i(push_entry),
        .pop_i      (pop),
        .head_o     (head),
        .count_o    (fifo_cnt)
    );

    // A redirect turns every response still in flight into one to be discarded.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            pc_f_q   <= RESET_VECTOR;
            pc_rsp_q <= RESET_VECTOR;
            outst_q  <= 2'd0;
            drop_q   <= 2'd0;
        end else begin
            outst_q <= outst_q + 2'(req_fire) - 2'(rsp_fire);
            if (pcsrc_e) begin
                pc_f_q   <= pc_target_e;
                pc_rsp_q <= pc_target_e;
                drop_q   <= outst_q - 2'(rsp_fire);
            end else begin
                if (req_fire) pc_f_q <= pc_f_q + 32'd4;
                if (push) pc_rsp_q <= pc_rsp_q + 32'd4;
                if (rsp_fire && drop_q != 2'd0) drop_q <= drop_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            instr_q    <= NOP_INSTR;
            pc_q       <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else if (pop) begin
            instr_q    <= head.instr;
            pc_q       <= head.pc;
            pc_plus4_q <= head.pc + 32'd4;
            valid_q    <= 1'b1;
        end else if (bubble) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end
    end

    assign instr_d    = instr_q;
    assign pc_d       = pc_q;
    assign pc_plus4_d = pc_plus4_q;
    assign valid_d    = valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [XLEN-1:0] fetch_q, bubble_q;
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            fetch_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (pop && fetch_q != '1) fetch_q <= fetch_q + 32'd1;
            if (bubble && !stall_d && bubble_q != '1) bubble_q <= bubble_q + 32'd1;
        end
    end
    assign fetch_cnt  = fetch_q;
    assign bubble_cnt = bubble_q;
`else
    assign fetch_cnt  = '0;
    assign bubble_cnt = '0;
`endif
endmodule
